// File: rtl/jtframe_z80_sysctl_pkg.sv
// Shared constants and helpers for the Z80 system controller.
// Holds the default refresh-address bit map used by Popeye and Sky Skipper boards.
package jtframe_z80_sysctl_pkg;

    // Refresh-cycle address bits used by the original Popeye/Sky Skipper glue
    localparam int POPEYE_NMI_BIT   = 9;
    localparam int POPEYE_KICK_BIT  = 5;
    localparam int SKYSKIP_NMI_BIT  = 9;
    localparam int SKYSKIP_KICK_BIT = 5;

    localparam int NMI_BIT_DEF  = POPEYE_NMI_BIT;
    localparam int KICK_BIT_DEF = POPEYE_KICK_BIT;

    typedef struct packed {
        logic nmi_en;
        logic kick;
    } rfsh_ctl_t;

    function automatic logic rising(input logic now, input logic last);
        return now & ~last;
    endfunction

endpackage

// File: rtl/jtframe_z80_sysctl_wait.sv
// SDRAM wait-state generator: one pending flag per chip-select channel,
// set on the chip-select rising edge and cleared by the channel's data-valid strobe.
module jtframe_z80_sysctl_wait
    import jtframe_z80_sysctl_pkg::*;
#(
    parameter int NCS = 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCS-1:0] cs,
    input  logic [NCS-1:0] ok,
    input  logic           pause,
    output logic           wait_n
);

    logic [NCS-1:0] cs_l;
    logic [NCS-1:0] pending;
    logic [NCS-1:0] cs_edge;

    always_comb begin
        cs_edge = '0;
        for (int i = 0; i < NCS; i++) begin
            cs_edge[i] = rising(cs[i], cs_l[i]);
        end
    end

    // An ok arriving with a new edge belongs to the previous access, so the edge wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_l    <= '0;
            pending <= '0;
            wait_n  <= 1'b1;
        end else begin
            cs_l    <= cs;
            pending <= cs_edge | (pending & ~ok);
            wait_n  <= ~(|pending | pause);
        end
    end

endmodule

// File: rtl/jtframe_z80_sysctl.sv
// Z80 system controller: SDRAM wait states, VB-driven NMI/INT, refresh-address watchdog.
// Define SYSCTL_WATCHDOG_EN to build the watchdog; otherwise cpu_rst is tied low.
module jtframe_z80_sysctl
    import jtframe_z80_sysctl_pkg::*;
#(
    parameter int NCS      = 1,
    parameter int NMI_BIT  = NMI_BIT_DEF,
    parameter int KICK_BIT = KICK_BIT_DEF,
    parameter int INT_EN   = 0,
    parameter int WDW      = 4,
    parameter int RST_LEN  = 4
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           pause,
    input  logic [NCS-1:0] cs,
    input  logic [NCS-1:0] ok,
    input  logic           mreq_n,
    input  logic           iorq_n,
    input  logic           m1_n,
    input  logic           rfsh_n,
    input  logic [15:0]    A,
    input  logic           vb,
    output logic           wait_n,
    output logic           nmi_n,
    output logic           int_n,
    output logic           cpu_rst
);

    logic      rf;
    logic      rf_l;
    logic      vb_l;
    logic      vb_pos;
    logic      iack;
    rfsh_ctl_t ctl;
    logic      unused;

    assign rf     = ~rfsh_n & ~mreq_n;
    assign vb_pos = rising(vb, vb_l);
    assign iack   = ~m1_n & ~iorq_n;
    assign unused = &{1'b0, A, iack, ctl.kick};

    jtframe_z80_sysctl_wait #(
        .NCS    ( NCS    )
    ) u_wait (
        .clk    ( clk    ),
        .rst    ( rst    ),
        .cs     ( cs     ),
        .ok     ( ok     ),
        .pause  ( pause  ),
        .wait_n ( wait_n )
    );

    // Refresh cycles carry the NMI enable and watchdog kick on the address bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_l       <= 1'b0;
            vb_l       <= 1'b0;
            ctl.nmi_en <= 1'b0;
            ctl.kick   <= 1'b1;
            nmi_n      <= 1'b1;
        end else if (cen) begin
            rf_l <= rf;
            vb_l <= vb;
            if (rising(rf, rf_l)) begin
                ctl.nmi_en <= A[NMI_BIT];
                ctl.kick   <= A[KICK_BIT];
            end
            if (!ctl.nmi_en) begin
                nmi_n <= 1'b1;
            end else if (vb_pos) begin
                nmi_n <= 1'b0;
            end
        end
    end

    generate
        if (INT_EN != 0) begin : g_int
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    int_n <= 1'b1;
                end else if (cen) begin
                    if (vb_pos) begin
                        int_n <= 1'b0;
                    end else if (iack) begin
                        int_n <= 1'b1;
                    end
                end
            end
        end else begin : g_no_int
            assign int_n = 1'b1;
        end
    endgenerate

`ifdef SYSCTL_WATCHDOG_EN
    localparam int PW = $clog2(RST_LEN + 1);

    logic           vb_wl;
    logic           vb_wpos;
    logic           wd_hold;
    logic           wd_carry;
    logic [WDW-1:0] wd_cnt;
    logic [PW-1:0]  pulse;

    // The watchdog sees every VB edge on clk, independent of the CPU clock enable
    assign vb_wpos  = rising(vb, vb_wl);
    assign wd_hold  = ctl.nmi_en | ctl.kick;
    assign wd_carry = ~wd_hold & vb_wpos & (&wd_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_wl   <= 1'b0;
            wd_cnt  <= '0;
            pulse   <= '0;
            cpu_rst <= 1'b0;
        end else begin
            vb_wl   <= vb;
            cpu_rst <= pulse != '0;
            if (wd_hold) begin
                wd_cnt <= '0;
            end else if (vb_wpos) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_carry) begin
                pulse <= PW'(RST_LEN);
            end else if (pulse != '0) begin
                pulse <= pulse - 1'b1;
            end
        end
    end
`else
    assign cpu_rst = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_z80_sysctl.sv
// Scoreboard bench for jtframe_z80_sysctl (NCS=2, INT_EN=1); expectations adapt to SYSCTL_WATCHDOG_EN.
module tb_jtframe_z80_sysctl;

    localparam int NCS     = 2;
    localparam int WDW     = 4;
    localparam int RST_LEN = 4;
`ifdef SYSCTL_WATCHDOG_EN
    localparam int WD = 1;
`else
    localparam int WD = 0;
`endif

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           cen    = 1'b0;
    logic           pause  = 1'b0;
    logic [NCS-1:0] cs     = '0;
    logic [NCS-1:0] ok     = '0;
    logic           mreq_n = 1'b1;
    logic           iorq_n = 1'b1;
    logic           m1_n   = 1'b1;
    logic           rfsh_n = 1'b1;
    logic [15:0]    A      = '0;
    logic           vb     = 1'b0;
    logic           wait_n;
    logic           nmi_n;
    logic           int_n;
    logic           cpu_rst;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rst_hi = 0;

    jtframe_z80_sysctl #(
        .NCS      ( NCS     ),
        .NMI_BIT  ( 9       ),
        .KICK_BIT ( 5       ),
        .INT_EN   ( 1       ),
        .WDW      ( WDW     ),
        .RST_LEN  ( RST_LEN )
    ) dut (
        .clk     ( clk     ),
        .rst     ( rst     ),
        .cen     ( cen     ),
        .pause   ( pause   ),
        .cs      ( cs      ),
        .ok      ( ok      ),
        .mreq_n  ( mreq_n  ),
        .iorq_n  ( iorq_n  ),
        .m1_n    ( m1_n    ),
        .rfsh_n  ( rfsh_n  ),
        .A       ( A       ),
        .vb      ( vb      ),
        .wait_n  ( wait_n  ),
        .nmi_n   ( nmi_n   ),
        .int_n   ( int_n   ),
        .cpu_rst ( cpu_rst )
    );

    always #5 clk = ~clk;
    always @(posedge clk) cen <= ~cen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, cpu_rst, int_n, nmi_n, wait_n};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cpu_rst === 1'b1) rst_hi++;
        end
    endtask

    task automatic refresh(input logic nmi, input logic kick);
        A      = 16'($urandom);
        A[9]   = nmi;
        A[5]   = kick;
        rfsh_n = 1'b0;
        mreq_n = 1'b0;
        tick(4);
        rfsh_n = 1'b1;
        mreq_n = 1'b1;
        tick(4);
    endtask

    task automatic vb_edge();
        vb = 1'b1;
        tick(4);
        vb = 1'b0;
        tick(4);
    endtask

    task automatic iack();
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick(4);
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        tick(2);
    endtask

    initial begin
        tick(3);
        push("reset_outs", 32'b0111); pop(outs());
        rst = 1'b0;
        tick();

        // channel 1: stall while ok low, release one clk after ok
        cs = 2'b10;
        tick(); push("w1_pre", 1); pop(wait_n);
        tick(); push("w1_low", 0); pop(wait_n);
        tick(3); push("w1_hold", 0); pop(wait_n);
        ok = 2'b10;
        tick(); ok = '0; push("w1_ok_clk", 0); pop(wait_n);
        tick(); push("w1_release", 1); pop(wait_n);
        cs = '0;
        tick();

        // channel 0: edge and ok in the same clk, edge wins
        cs = 2'b01;
        ok = 2'b01;
        tick(); ok = '0;
        tick(); push("w0_edge_wins", 0); pop(wait_n);
        tick(4); push("w0_hold", 0); pop(wait_n);
        ok = 2'b01;
        tick(); ok = '0;
        tick(); push("w0_release", 1); pop(wait_n);
        cs = '0;
        tick();

        pause = 1'b1;
        tick(); push("pause", 0); pop(wait_n);
        pause = 1'b0;
        tick(); push("unpause", 1); pop(wait_n);

        // NMI and INT
        refresh(1'b1, 1'b0);
        vb_edge(); push("nmi_int_set", 32'b0001); pop(outs());
        iack(); push("iack_clear", 32'b0101); pop(outs());
        refresh(1'b0, 1'b0); push("nmi_disable", 32'b0111); pop(outs());
        vb_edge(); push("nmi_stays_off", 32'b0011); pop(outs());
        iack(); push("iack_clear2", 32'b0111); pop(outs());
        for (int i = 0; i < 4 && !cen; i++) tick();
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        vb     = 1'b1;
        tick();
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        tick(3);
        vb = 1'b0;
        tick(4);
        push("iack_vb_same", 32'b0011); pop(outs());

        // watchdog: kick mid-count restarts it, then 16 edges overflow
        rst_hi = 0;
        refresh(1'b0, 1'b1);
        refresh(1'b0, 1'b0);
        repeat (10) vb_edge();
        refresh(1'b0, 1'b1);
        refresh(1'b0, 1'b0);
        repeat (15) vb_edge();
        push("wd_no_early", 0); pop(rst_hi);
        vb_edge();
        tick(4);
        push("wd_pulse_len", WD * RST_LEN); pop(rst_hi);
        rst_hi = 0;
        repeat (64) vb_edge();
        push("wd_64_edges", WD * 4 * RST_LEN); pop(rst_hi);
        push("wd_nmi_off", 1); pop(nmi_n);

        // asynchronous reset in the middle of a stalled access
        cs = 2'b10;
        tick(3); push("mid_wait", 0); pop(wait_n);
        #2 rst = 1'b1;
        #1;
        push("rst_async", 32'b0111); pop(outs());
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
